// File: rtl/button_sr_reader.sv
// Scans a 74HC165-style button chain, detects new presses and hands one key index per
// press to the consumer over valid/ready. Define BUTTON_SR_READER_DEBOUNCE_EN for debounce.
module button_sr_reader #(
  parameter int  NUM_BUTTONS    = 16,
  parameter int  SCAN_INTERVAL  = 1000,
  parameter int  DEBOUNCE_SCANS = 4,
  localparam int KEY_WIDTH      = $clog2(NUM_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_sr_data,
  output logic                 o_sr_clk,
  output logic                 o_sr_load_n,
  output logic [KEY_WIDTH-1:0] o_key,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_dropped
);

  localparam int IdleW  = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
  localparam int PhaseW = $clog2(2 * NUM_BUTTONS);
  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(SCAN_INTERVAL - 1);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(2 * NUM_BUTTONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    EVAL
  } state_t;

  state_t                 state_q;
  logic [IdleW-1:0]       idleCnt_q;
  logic [PhaseW-1:0]      phase_q;
  logic [NUM_BUTTONS-1:0] raw_q;
  logic [NUM_BUTTONS-1:0] stable_q;
  logic [NUM_BUTTONS-1:0] stable_d;
  logic [NUM_BUTTONS-1:0] newPress;
  logic [KEY_WIDTH-1:0]   newIdx;
  logic [KEY_WIDTH-1:0]   key_q;
  logic                   valid_q;
  logic                   dropped_q;
  logic                   srClk_q;
  logic                   loadN_q;

  function automatic logic [KEY_WIDTH-1:0] lowestIndex(input logic [NUM_BUTTONS-1:0] vec);
    lowestIndex = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (vec[i]) lowestIndex = KEY_WIDTH'(i);
    end
  endfunction

`ifdef BUTTON_SR_READER_DEBOUNCE_EN
  localparam int DbW = $clog2(DEBOUNCE_SCANS);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_SCANS - 1);

  logic [NUM_BUTTONS-1:0] prevRaw_q;
  logic [DbW-1:0]         dbCnt_q;
  logic [DbW-1:0]         dbCnt_d;

  // A change is only accepted once the whole vector has repeated for enough scans.
  always_comb begin
    dbCnt_d  = '0;
    stable_d = stable_q;
    if (raw_q == prevRaw_q) begin
      dbCnt_d = (dbCnt_q == DbLast) ? dbCnt_q : dbCnt_q + 1'b1;
    end
    if (dbCnt_d == DbLast) begin
      stable_d = raw_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevRaw_q <= '0;
      dbCnt_q   <= '0;
    end else if (state_q == EVAL) begin
      prevRaw_q <= raw_q;
      dbCnt_q   <= dbCnt_d;
    end
  end
`else
  always_comb begin
    stable_d = raw_q;
  end
`endif

  always_comb begin
    newPress = stable_d & ~stable_q;
    newIdx   = lowestIndex(newPress);
  end

  // Scan sequencer plus output holding register; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idleCnt_q <= '0;
      phase_q   <= '0;
      raw_q     <= '0;
      stable_q  <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
      srClk_q   <= 1'b0;
      loadN_q   <= 1'b1;
    end else begin
      dropped_q <= 1'b0;
      if (valid_q && i_ready) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (idleCnt_q == IdleLast) begin
            idleCnt_q <= '0;
            loadN_q   <= 1'b0;
            state_q   <= LOAD;
          end else begin
            idleCnt_q <= idleCnt_q + 1'b1;
          end
        end
        LOAD: begin
          loadN_q <= 1'b1;
          phase_q <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          // Even phases hold the shift clock low and sample Q7 at their closing edge.
          if (!phase_q[0]) begin
            raw_q   <= {raw_q[NUM_BUTTONS-2:0], i_sr_data};
            srClk_q <= 1'b1;
          end else begin
            srClk_q <= 1'b0;
          end
          if (phase_q == PhaseLast) begin
            phase_q <= '0;
            state_q <= EVAL;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        EVAL: begin
          stable_q <= stable_d;
          if (newPress != '0) begin
            if (!valid_q || i_ready) begin
              key_q   <= newIdx;
              valid_q <= 1'b1;
            end else begin
              dropped_q <= 1'b1;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_sr_clk    = srClk_q;
  assign o_sr_load_n = loadN_q;
  assign o_key       = key_q;
  assign o_valid     = valid_q;
  assign o_dropped   = dropped_q;

endmodule

// File: tb/tb_button_sr_reader.sv
// Self-checking bench for button_sr_reader: models the 74HC165 chain and predicts
// reported keys per scan from a scan-history reference model.
module tb_button_sr_reader;

  localparam int N      = 16;
  localparam int SI     = 1000;
  localparam int DS     = 4;
  localparam int PERIOD = SI + 2 * N + 2;
`ifdef BUTTON_SR_READER_DEBOUNCE_EN
  localparam int HOLD      = DS;
  localparam int RAND_ITER = 4;
  localparam int HOLD_MAX  = 5;
`else
  localparam int HOLD      = 1;
  localparam int RAND_ITER = 12;
  localparam int HOLD_MAX  = 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ready = 1'b0;
  logic         srData;
  logic         srClk;
  logic         srLoadN;
  logic [3:0]   key;
  logic         valid;
  logic         dropped;
  logic [N-1:0] buttons = '0;
  logic [N-1:0] chain = '0;

  int cycleCount = 0;
  int lastLoadCycle = 0;
  bit havePrev = 1'b0;
  int checks = 0;
  int passes = 0;

  logic [N-1:0] modelStable;
  logic         modelVld;
  logic [3:0]   modelKey;
  logic         expDrop;
  logic [N-1:0] hist[$];

  button_sr_reader #(
    .NUM_BUTTONS   (N),
    .SCAN_INTERVAL (SI),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sr_data  (srData),
    .o_sr_clk   (srClk),
    .o_sr_load_n(srLoadN),
    .o_key      (key),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_dropped  (dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // 74HC165 behaviour: parallel load while load_n is low, shift towards Q7 on clock rise.
  always @(negedge srLoadN or posedge srClk) begin
    if (!srLoadN) chain <= buttons;
    else          chain <= {chain[N-2:0], 1'b0};
  end

  assign srData = chain[N-1];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [N-1:0] b, input logic r);
    buttons = b;
    ready   = r;
  endtask

  task automatic modelReset;
    modelStable = '0;
    modelVld    = 1'b0;
    modelKey    = '0;
    expDrop     = 1'b0;
    hist.delete();
    hist.push_back('0);
  endtask

  // One scan's worth of behaviour: which presses become stable, which gets reported.
  task automatic modelScan(input logic [N-1:0] raw, input logic rdy);
    logic [N-1:0] stNext;
    logic [N-1:0] newP;
    logic         vldBefore;
    bit           allSame;
    bit           found;
`ifdef BUTTON_SR_READER_DEBOUNCE_EN
    hist.push_back(raw);
    if (hist.size() > DS) void'(hist.pop_front());
    stNext = modelStable;
    if (hist.size() == DS) begin
      allSame = 1'b1;
      foreach (hist[i]) if (hist[i] != raw) allSame = 1'b0;
      if (allSame) stNext = raw;
    end
`else
    allSame = 1'b1;
    stNext  = raw;
`endif
    newP        = stNext & ~modelStable;
    modelStable = stNext;
    vldBefore   = modelVld && !rdy;
    expDrop     = 1'b0;
    if (newP != '0) begin
      if (!vldBefore || rdy) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (newP[i] && !found) begin
            modelKey = 4'(i);
            found    = 1'b1;
          end
        end
        modelVld = 1'b1;
      end else begin
        expDrop = 1'b1;
      end
    end else begin
      modelVld = vldBefore;
    end
  endtask

  task automatic waitLoadCount(output int n);
    n = 0;
    while (srLoadN && n < PERIOD + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (srLoadN) checkOutput("loadTimeout", 32'(srLoadN), 32'd0);
  endtask

  task automatic waitForLoad;
    int n;
    waitLoadCount(n);
    if (havePrev) checkOutput("scanPeriod", 32'(cycleCount - lastLoadCycle), 32'(PERIOD));
    lastLoadCycle = cycleCount;
    havePrev      = 1'b1;
  endtask

  task automatic finishScan;
    int   pulses;
    logic prevClk;
    pulses  = 0;
    prevClk = srClk;
    for (int k = 1; k <= 2 * N + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) checkOutput("loadWidth", 32'(srLoadN), 32'd1);
      if (srClk && !prevClk) pulses++;
      prevClk = srClk;
    end
    checkOutput("srClkPulses", pulses, 32'(N));
    modelScan(buttons, ready);
    @(posedge clk);
    #1;
    checkOutput("valid", 32'(valid), 32'(modelVld));
    checkOutput("key", 32'(key), 32'(modelKey));
    checkOutput("dropped", 32'(dropped), 32'(expDrop));
    @(posedge clk);
    #1;
    checkOutput("droppedPulse", 32'(dropped), 32'd0);
    if (ready) modelVld = 1'b0;
    checkOutput("validAfter", 32'(valid), 32'(modelVld));
  endtask

  task automatic runScan;
    waitForLoad();
    finishScan();
  endtask

  task automatic runStep(input logic [N-1:0] b, input logic r, input int scans);
    applyStimulus(b, r);
    repeat (scans) runScan();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
    checkOutput({tag, "_key"}, 32'(key), 32'd0);
    checkOutput({tag, "_dropped"}, 32'(dropped), 32'd0);
    checkOutput({tag, "_srClk"}, 32'(srClk), 32'd0);
    checkOutput({tag, "_loadN"}, 32'(srLoadN), 32'd1);
  endtask

  initial begin
    int n;
    modelReset();
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    applyStimulus('0, 1'b1);
    rst_n = 1'b1;
    waitLoadCount(n);
    checkOutput("firstScanDelay", 32'(n), 32'(SI));
    lastLoadCycle = cycleCount;
    havePrev      = 1'b1;
    finishScan();

    runStep('0, 1'b1, 2);
    runStep(16'h0020, 1'b1, HOLD);
    runStep(16'h0020, 1'b1, 2);
    runStep('0, 1'b1, HOLD);
    runStep(16'h0208, 1'b1, HOLD);
    runStep(16'h0208, 1'b1, 1);
    runStep(16'h0008, 1'b1, HOLD);
    runStep(16'h0208, 1'b1, HOLD);
    runStep('0, 1'b0, HOLD);
    runStep(16'h0004, 1'b0, HOLD);
    runStep('0, 1'b0, HOLD);
    runStep(16'h0080, 1'b0, HOLD);
    runStep('0, 1'b1, 1);

`ifdef BUTTON_SR_READER_DEBOUNCE_EN
    runStep(16'h0002, 1'b1, 1);
    runStep('0, 1'b1, 1);
    runStep(16'h0002, 1'b1, 4);
    runStep('0, 1'b1, 4);
    runStep(16'h0002, 1'b1, 2);
    runStep('0, 1'b1, 2);
`endif

    for (int it = 0; it < RAND_ITER; it++) begin
      runStep(N'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)), $urandom_range(1, HOLD_MAX));
    end

    runStep('0, 1'b1, HOLD);
    runStep(16'h0010, 1'b0, HOLD);
    waitForLoad();
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midScanReset");
    @(posedge clk);
    #1;
    checkResetOutputs("resetHeld");
    rst_n = 1'b1;
    modelReset();
    waitLoadCount(n);
    checkOutput("restartDelay", 32'(n), 32'(SI));
    lastLoadCycle = cycleCount;
    finishScan();
    repeat (HOLD) runScan();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
